fetch_prefetch_unit: RTL and testbench

Parametrised successor to the single-word fetch stage. It runs a Wishbone classic master that fetches instructions ahead of decode into a FIFO_DEPTH-entry prefetch queue. Each queue entry holds the instruction, its PC and a bus-fault flag. Decode takes entries through a valid/ready handshake. A jump flushes the queue and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_prefetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the prefetching instruction fetch stage: queue entry layout,
// bus FSM states and fixed Wishbone classic-read attributes.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD,
        HALT
    } fetch_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [3:0] WB_SEL_WORD    = 4'hF;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue with a registered head. Flush wins over push; a
// same-cycle pop is simply absorbed by the flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  fetch_entry_t      push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output fetch_entry_t      head_o,
    output logic [LVL_W-1:0]  level_o
);

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     head_q;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_en, pop_en;

    assign pop_en  = pop_i && (level_q != '0);
    assign push_en = push_i && !flush_i;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end else begin
            if (push_en) wr_d = wr_q + 1'b1;
            if (pop_en)  rd_d = rd_q + 1'b1;
            level_d = level_q + LVL_W'(push_en) - LVL_W'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_q] <= push_data_i;
    end

    // Head is preloaded from the next read slot; bypass when that slot is written now.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            if (flush_i || level_d == '0)
                head_q <= '0;
            else if (push_en && wr_q == rd_d)
                head_q <= push_data_i;
            else
                head_q <= mem[rd_d];
        end
    end

    assign head_o  = head_q;
    assign level_o = level_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Wishbone classic fetch master that keeps a small instruction queue ahead of
// decode, with jump flush, retry reissue and halt-on-bus-error.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter  int               XLEN         = 32,
    parameter  int               FIFO_DEPTH   = 4,
    parameter  logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    localparam int               LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              CYC,
    output logic              STB,
    output logic              WE,
    output logic [XLEN-1:0]   ADR,
    output logic [XLEN-1:0]   DAT_O,
    output logic [3:0]        SEL,
    output logic [2:0]        CTI_O,
    input  logic              ACK,
    input  logic              ERR,
    input  logic              RTY,
    input  logic [XLEN-1:0]   DAT_I,
    output logic [XLEN-1:0]   INS_O,
    output logic [XLEN-1:0]   PC_ADDR,
    output logic              ins_fault,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic [XLEN-1:0]   PC_JMP,
    input  logic              jmp_s,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d, tgt_q, tgt_d, jmp_pc;
    logic             push, pop, flush, term;
    fetch_entry_t     push_data, head;
    logic [LVL_W-1:0] level, lvl_after;

    assign term      = ACK | ERR | RTY;
    assign jmp_pc    = PC_JMP & ~XLEN'(3);
    assign pop       = ins_valid && ins_ready;
    assign lvl_after = level + LVL_W'(1) - LVL_W'(pop);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        tgt_d           = tgt_q;
        push            = 1'b0;
        flush           = 1'b0;
        push_data.pc    = pc_q;
        push_data.ins   = DAT_I;
        push_data.fault = 1'b0;
        if (jmp_s) begin
            flush = 1'b1;
            case (state_q)
                // The outstanding cycle must still complete at the old address.
                REQ, DISCARD: begin
                    if (term) begin
                        state_d = IDLE;
                        pc_d    = jmp_pc;
                    end else begin
                        state_d = DISCARD;
                        tgt_d   = jmp_pc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pc_d    = jmp_pc;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: if (level < FULL) state_d = REQ;
                REQ: begin
                    if (ERR) begin
                        push            = 1'b1;
                        push_data.ins   = '0;
                        push_data.fault = 1'b1;
                        state_d         = HALT;
                    end else if (RTY) begin
                        state_d = IDLE;
                    end else if (ACK) begin
                        push    = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = (lvl_after < FULL) ? REQ : IDLE;
                    end
                end
                DISCARD: begin
                    if (term) begin
                        state_d = IDLE;
                        pc_d    = tgt_q;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .level_o     (level)
    );

    assign CYC        = (state_q == REQ) || (state_q == DISCARD);
    assign STB        = CYC;
    assign WE         = 1'b0;
    assign ADR        = pc_q;
    assign DAT_O      = '0;
    assign SEL        = WB_SEL_WORD;
    assign CTI_O      = WB_CTI_CLASSIC;
    assign INS_O      = head.ins;
    assign PC_ADDR    = head.pc;
    assign ins_fault  = head.fault;
    assign ins_valid  = (level != '0);
    assign fifo_level = level;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: scripted Wishbone slave responses,
// queue pops logged per cycle, expected values written out by hand.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        CYC, STB, WE;
    logic [31:0] ADR, DAT_O;
    logic [3:0]  SEL;
    logic [2:0]  CTI_O;
    logic        ACK = 1'b0, ERR = 1'b0, RTY = 1'b0;
    logic [31:0] DAT_I = '0;
    logic [31:0] INS_O, PC_ADDR;
    logic        ins_fault, ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] PC_JMP = '0;
    logic        jmp_s = 1'b0;
    logic [2:0]  fifo_level;

    int errs = 0;
    int checks = 0;
    bit auto_ack = 1'b0;
    int n;

    logic [31:0] acked[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .XLEN(32), .FIFO_DEPTH(4), .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR),
        .DAT_O(DAT_O), .SEL(SEL), .CTI_O(CTI_O), .ACK(ACK), .ERR(ERR),
        .RTY(RTY), .DAT_I(DAT_I), .INS_O(INS_O), .PC_ADDR(PC_ADDR),
        .ins_fault(ins_fault), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .PC_JMP(PC_JMP), .jmp_s(jmp_s), .fifo_level(fifo_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    // Log this cycle's pop and bus termination, advance one clock, then let the
    // slave answer the (possibly new) request when auto_ack is set.
    task automatic tick();
        if (rst && ins_valid && ins_ready) begin
            pop_pc.push_back(PC_ADDR);
            pop_ins.push_back(INS_O);
            $display("pop  pc=%h ins=%h fault=%0b", PC_ADDR, INS_O, ins_fault);
        end
        if (rst && CYC && (ACK || ERR || RTY)) begin
            acked.push_back(ADR);
            $display("bus  adr=%h ack=%0b err=%0b rty=%0b jmp=%0b", ADR, ACK, ERR, RTY, jmp_s);
        end
        @(posedge clk);
        #1;
        ACK   = auto_ack && CYC;
        DAT_I = ADR ^ 32'hC0DE_0000;
    endtask

    task automatic do_reset();
        rst = 1'b0; ACK = 1'b0; ERR = 1'b0; RTY = 1'b0; jmp_s = 1'b0; auto_ack = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        acked.delete();
        pop_pc.delete();
        pop_ins.delete();
    endtask

    initial begin
        // 1: reset state, first request, back-to-back fetch with decode always ready
        ins_ready = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        check_eq("rst_cyc", CYC, 0);
        check_eq("rst_adr", ADR, 32'h0);
        check_eq("rst_valid", ins_valid, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_ins", INS_O, 32'h0);
        check_eq("rst_pc", PC_ADDR, 32'h0);
        check_eq("const_wb", {WE, SEL, CTI_O}, {1'b0, 4'hF, 3'b000});
        check_eq("const_dat", DAT_O, 32'h0);
        rst = 1'b1;
        auto_ack = 1'b1;
        tick();
        check_eq("t1_first_req", {CYC, STB}, 2'b11);
        check_eq("t1_first_adr", ADR, 32'h0);
        check_eq("t1_not_yet_valid", ins_valid, 0);
        tick();
        check_eq("t1_latency_valid", ins_valid, 1);
        check_eq("t1_head_pc", PC_ADDR, 32'h0);
        n = 0;
        repeat (5) begin
            tick();
            if (!CYC) n++;
        end
        check_eq("t1_cyc_drops", n, 0);
        check_eq("t1_adr0", at(acked, 0), 32'h0);
        check_eq("t1_adr1", at(acked, 1), 32'h4);
        check_eq("t1_adr2", at(acked, 2), 32'h8);
        check_eq("t1_pop0_pc", at(pop_pc, 0), 32'h0);
        check_eq("t1_pop0_ins", at(pop_ins, 0), 32'hC0DE_0000);
        check_eq("t1_pop1_pc", at(pop_pc, 1), 32'h4);
        check_eq("t1_pop1_ins", at(pop_ins, 1), 32'hC0DE_0004);

        // 2: queue fills to 4 and stalls; one pop allows exactly one refetch
        ins_ready = 1'b0;
        do_reset();
        auto_ack = 1'b1;
        repeat (10) tick();
        check_eq("t2_fetches", acked.size(), 4);
        check_eq("t2_cyc_dropped", CYC, 0);
        check_eq("t2_level_full", fifo_level, 4);
        check_eq("t2_head_pc", PC_ADDR, 32'h0);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        repeat (5) tick();
        check_eq("t2_refetches", acked.size(), 5);
        check_eq("t2_refetch_adr", at(acked, 4), 32'h10);
        check_eq("t2_pops", pop_pc.size(), 1);
        check_eq("t2_level_refull", fifo_level, 4);
        check_eq("t2_new_head", PC_ADDR, 32'h4);

        // 3: jump while the fetch of 0x8 is outstanding
        ins_ready = 1'b1;
        do_reset();
        auto_ack = 1'b1;
        tick();
        tick();
        auto_ack = 1'b0;
        tick();
        check_eq("t3_pending_adr", ADR, 32'h8);
        jmp_s = 1'b1;
        PC_JMP = 32'h0000_0103;
        tick();
        jmp_s = 1'b0;
        check_eq("t3_hold_cyc", CYC, 1);
        check_eq("t3_hold_adr", ADR, 32'h8);
        check_eq("t3_flushed", ins_valid, 0);
        tick();
        tick();
        ACK = 1'b1;
        DAT_I = 32'hBAD0_BAD0;
        tick();
        check_eq("t3_cyc_end", CYC, 0);
        check_eq("t3_new_adr", ADR, 32'h100);
        check_eq("t3_dropped", fifo_level, 0);
        auto_ack = 1'b1;
        tick();
        check_eq("t3_req_target", {CYC, ADR}, {1'b1, 32'h100});
        tick();
        check_eq("t3_head_valid", ins_valid, 1);
        check_eq("t3_head_pc", PC_ADDR, 32'h100);
        check_eq("t3_head_ins", INS_O, 32'hC0DE_0100);

        // 4: retry on 0xC is reissued once, no gap or duplicate in the stream
        do_reset();
        auto_ack = 1'b1;
        repeat (4) tick();
        check_eq("t4_adr_c", ADR, 32'hC);
        auto_ack = 1'b0;
        ACK = 1'b0;
        RTY = 1'b1;
        tick();
        RTY = 1'b0;
        check_eq("t4_idle_gap", CYC, 0);
        check_eq("t4_adr_kept", ADR, 32'hC);
        tick();
        check_eq("t4_reissue", {CYC, ADR}, {1'b1, 32'hC});
        auto_ack = 1'b1;
        ACK = 1'b1;
        repeat (4) tick();
        check_eq("t4_pop0", at(pop_pc, 0), 32'h0);
        check_eq("t4_pop1", at(pop_pc, 1), 32'h4);
        check_eq("t4_pop2", at(pop_pc, 2), 32'h8);
        check_eq("t4_pop3", at(pop_pc, 3), 32'hC);
        check_eq("t4_pop3_ins", at(pop_ins, 3), 32'hC0DE_000C);
        check_eq("t4_pop4", at(pop_pc, 4), 32'h10);

        // 5: bus error on 0x14 halts fetching until a jump
        do_reset();
        auto_ack = 1'b1;
        repeat (6) tick();
        check_eq("t5_adr_14", ADR, 32'h14);
        auto_ack = 1'b0;
        ACK = 1'b0;
        ERR = 1'b1;
        tick();
        ERR = 1'b0;
        check_eq("t5_cyc_off", CYC, 0);
        check_eq("t5_fault_valid", ins_valid, 1);
        check_eq("t5_fault_pc", PC_ADDR, 32'h14);
        check_eq("t5_fault_flag", ins_fault, 1);
        check_eq("t5_fault_ins", INS_O, 32'h0);
        n = acked.size();
        repeat (5) tick();
        check_eq("t5_halt_cyc", CYC, 0);
        check_eq("t5_halt_no_req", acked.size(), n);
        jmp_s = 1'b1;
        PC_JMP = 32'h0000_0200;
        tick();
        jmp_s = 1'b0;
        auto_ack = 1'b1;
        tick();
        check_eq("t5_resume", {CYC, ADR}, {1'b1, 32'h200});
        tick();
        check_eq("t5_resume_valid", ins_valid, 1);
        check_eq("t5_resume_pc", PC_ADDR, 32'h200);

        // 6: pop + ACK + jump in one cycle, then reset in the middle of a request
        do_reset();
        auto_ack = 1'b1;
        tick();
        tick();
        check_eq("t6_pre_head", {ins_valid, PC_ADDR}, {1'b1, 32'h0});
        n = pop_pc.size();
        jmp_s = 1'b1;
        PC_JMP = 32'h0000_0300;
        tick();
        jmp_s = 1'b0;
        check_eq("t6_popped", pop_pc.size(), n + 1);
        check_eq("t6_popped_pc", at(pop_pc, n), 32'h0);
        check_eq("t6_level", fifo_level, 0);
        check_eq("t6_valid", ins_valid, 0);
        check_eq("t6_cyc", CYC, 0);
        check_eq("t6_adr", ADR, 32'h300);
        auto_ack = 1'b0;
        tick();
        check_eq("t6_req_300", {CYC, ADR}, {1'b1, 32'h300});
        rst = 1'b0;
        tick();
        check_eq("t6_rst_cyc", CYC, 0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check_eq("t6_rst_ack_ignored", fifo_level, 0);
        check_eq("t6_rst_adr", ADR, 32'h0);
        rst = 1'b1;
        auto_ack = 1'b1;
        tick();
        check_eq("t6_restart", {CYC, ADR}, {1'b1, 32'h0});
        tick();
        check_eq("t6_restart_head", {ins_valid, PC_ADDR}, {1'b1, 32'h0});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
